// File: rtl/icb_mem_arbiter_if.sv
// ICB bundle (command + response channels) shared by masters and the slave port.
// The "master" modport drives commands; the "slave" modport answers them.
interface icb_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_read;
  logic [DATA_W-1:0] cmd_wdata;
  logic [MASK_W-1:0] cmd_wmask;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_valid;
  logic              rsp_ready;

  modport master (
    output cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid, rsp_ready,
    input  cmd_ready, rsp_rdata, rsp_err, rsp_valid
  );

  modport slave (
    input  cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid, rsp_ready,
    output cmd_ready, rsp_rdata, rsp_err, rsp_valid
  );
endinterface

// File: rtl/icb_mem_arbiter.sv
// Two-master to one-slave ICB arbiter: round-robin command grant with a wait lock,
// in-order ID FIFO steering responses back to the issuing master.
module icb_mem_arbiter #(
  parameter int unsigned OUTSTANDING_N = 4,
  parameter int unsigned SIM_DELAY     = 1
) (
  input  logic       clk,
  input  logic       sys_resetn,
  icb_if.slave       m0,
  icb_if.slave       m1,
  icb_if.master      s,
  output logic [3:0] outstanding_cnt
);

  localparam int unsigned PTR_W = (OUTSTANDING_N > 1) ? $clog2(OUTSTANDING_N) : 1;
  localparam int unsigned CNT_W = 4;

  // Register update delay is a simulation-only notion; synthesizable state updates at the edge.
  if (SIM_DELAY > 0) begin : g_sim_delay
  end

  logic [OUTSTANDING_N-1:0] id_mem;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         cnt;
  logic                     lock;
  logic                     lock_id;
  logic                     last_id;

  logic sel_c;
  logic full_c;
  logic empty_c;
  logic head_c;
  logic s_cmd_valid_c;
  logic s_rsp_ready_c;
  logic cmd_hs_c;
  logic rsp_hs_c;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUTSTANDING_N - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Grant selection: a waiting (locked) master keeps the port; ties go to the non-last master.
  always_comb begin
    sel_c = 1'b0;
    if (lock)                          sel_c = lock_id;
    else if (m0.cmd_valid && m1.cmd_valid) sel_c = ~last_id;
    else if (m1.cmd_valid)             sel_c = 1'b1;
  end

  assign full_c        = (cnt == CNT_W'(OUTSTANDING_N));
  assign empty_c       = (cnt == '0);
  assign head_c        = id_mem[rd_ptr];
  assign s_cmd_valid_c = (m0.cmd_valid | m1.cmd_valid) & ~full_c;
  assign s_rsp_ready_c = (head_c ? m1.rsp_ready : m0.rsp_ready) & ~empty_c;
  assign cmd_hs_c      = s_cmd_valid_c & s.cmd_ready;
  assign rsp_hs_c      = s.rsp_valid & s_rsp_ready_c;

  // Command mux toward the slave
  assign s.cmd_valid = s_cmd_valid_c;
  assign s.cmd_addr  = sel_c ? m1.cmd_addr  : m0.cmd_addr;
  assign s.cmd_read  = sel_c ? m1.cmd_read  : m0.cmd_read;
  assign s.cmd_wdata = sel_c ? m1.cmd_wdata : m0.cmd_wdata;
  assign s.cmd_wmask = sel_c ? m1.cmd_wmask : m0.cmd_wmask;
  assign m0.cmd_ready = ~sel_c & s.cmd_ready & ~full_c;
  assign m1.cmd_ready =  sel_c & s.cmd_ready & ~full_c;

  // Response steering by FIFO head; held off entirely while nothing is in flight
  assign s.rsp_ready  = s_rsp_ready_c;
  assign m0.rsp_valid = s.rsp_valid & ~empty_c & ~head_c;
  assign m1.rsp_valid = s.rsp_valid & ~empty_c &  head_c;
  assign m0.rsp_rdata = s.rsp_rdata;
  assign m1.rsp_rdata = s.rsp_rdata;
  assign m0.rsp_err   = s.rsp_err;
  assign m1.rsp_err   = s.rsp_err;

  assign outstanding_cnt = cnt;

  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      id_mem  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      lock    <= 1'b0;
      lock_id <= 1'b0;
      last_id <= 1'b1;
    end else begin
      if (cmd_hs_c) begin
        id_mem[wr_ptr] <= sel_c;
        wr_ptr         <= ptr_next(wr_ptr);
        last_id        <= sel_c;
        lock           <= 1'b0;
      end else if (s_cmd_valid_c && !s.cmd_ready) begin
        lock    <= 1'b1;
        lock_id <= sel_c;
      end
      if (rsp_hs_c) rd_ptr <= ptr_next(rd_ptr);
      case ({cmd_hs_c, rsp_hs_c})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_icb_mem_arbiter.sv
// Scoreboard bench: expected grants/responses queued at drive time, popped at handshakes.
`timescale 1ns/1ps
module tb_icb_mem_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        rd;
  } exp_t;

  logic clk;
  logic sys_resetn;
  logic [3:0] outstanding_cnt;

  icb_if m0_bus ();
  icb_if m1_bus ();
  icb_if s_bus ();

  icb_mem_arbiter #(.OUTSTANDING_N(4), .SIM_DELAY(1)) dut (
    .clk             (clk),
    .sys_resetn      (sys_resetn),
    .m0              (m0_bus),
    .m1              (m1_bus),
    .s               (s_bus),
    .outstanding_cnt (outstanding_cnt)
  );

  exp_t exp_cmd[$];
  exp_t exp_rsp[$];
  int   n_pass  = 0;
  int   n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic id, input logic [31:0] addr, input logic rd);
    exp_t e;
    e.id = id; e.data = addr; e.rd = rd;
    exp_cmd.push_back(e);
  endtask

  task automatic push_rsp(input logic id, input logic [31:0] data);
    exp_t e;
    e.id = id; e.data = data; e.rd = 1'b0;
    exp_rsp.push_back(e);
  endtask

  task automatic do_reset();
    sys_resetn = 1'b0;
    tick();
    sys_resetn = 1'b1;
  endtask

  // Handshake monitor: every accepted command / delivered response must match the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (sys_resetn) begin
      if (s_bus.cmd_valid && s_bus.cmd_ready) begin
        if (exp_cmd.size() == 0) check("unexpected_cmd", 64'd1, 64'd0);
        else begin
          e = exp_cmd.pop_front();
          check("grant", {62'd0, m1_bus.cmd_ready, m0_bus.cmd_ready}, e.id ? 64'd2 : 64'd1);
          check("cmd_addr", 64'(s_bus.cmd_addr), 64'(e.data));
          check("cmd_read", 64'(s_bus.cmd_read), 64'(e.rd));
        end
      end
      if (m0_bus.rsp_valid && m1_bus.rsp_valid) check("rsp_both_valid", 64'd1, 64'd0);
      if ((m0_bus.rsp_valid && m0_bus.rsp_ready) || (m1_bus.rsp_valid && m1_bus.rsp_ready)) begin
        if (exp_rsp.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
        else begin
          e = exp_rsp.pop_front();
          check("rsp_id", 64'(m1_bus.rsp_valid), 64'(e.id));
          check("rsp_rdata", e.id ? 64'(m1_bus.rsp_rdata) : 64'(m0_bus.rsp_rdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    sys_resetn = 1'b0;
    m0_bus.cmd_addr = '0; m0_bus.cmd_read = 1'b0; m0_bus.cmd_wdata = '0;
    m0_bus.cmd_wmask = '0; m0_bus.cmd_valid = 1'b0; m0_bus.rsp_ready = 1'b1;
    m1_bus.cmd_addr = '0; m1_bus.cmd_read = 1'b0; m1_bus.cmd_wdata = '0;
    m1_bus.cmd_wmask = '0; m1_bus.cmd_valid = 1'b0; m1_bus.rsp_ready = 1'b1;
    s_bus.cmd_ready = 1'b0; s_bus.rsp_rdata = '0; s_bus.rsp_err = 1'b0; s_bus.rsp_valid = 1'b0;
    tick();
    tick();
    sys_resetn = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_cnt", 64'(outstanding_cnt), 64'd0);
    check("rst_s_cmd_valid", 64'(s_bus.cmd_valid), 64'd0);
    check("rst_s_rsp_ready", 64'(s_bus.rsp_ready), 64'd0);
    tick();

    // Single master read, response two cycles after accept
    m0_bus.cmd_valid = 1'b1; m0_bus.cmd_addr = 32'h100; m0_bus.cmd_read = 1'b1;
    s_bus.cmd_ready = 1'b1;
    push_cmd(1'b0, 32'h100, 1'b1);
    tick();
    m0_bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("single_cnt_1", 64'(outstanding_cnt), 64'd1);
    tick();
    s_bus.rsp_valid = 1'b1; s_bus.rsp_rdata = 32'hDEADBEEF;
    push_rsp(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    check("single_m1_rsp_valid", 64'(m1_bus.rsp_valid), 64'd0);
    tick();
    s_bus.rsp_valid = 1'b0;
    @(negedge clk);
    check("single_cnt_0", 64'(outstanding_cnt), 64'd0);
    tick();

    // Round-robin tie from reset, filling the FIFO
    do_reset();
    m0_bus.cmd_valid = 1'b1; m0_bus.cmd_addr = 32'h200; m0_bus.cmd_read = 1'b1;
    m1_bus.cmd_valid = 1'b1; m1_bus.cmd_addr = 32'h300; m1_bus.cmd_read = 1'b0;
    m1_bus.cmd_wdata = 32'h5555_AAAA; m1_bus.cmd_wmask = 4'hF;
    push_cmd(1'b0, 32'h200, 1'b1); push_cmd(1'b1, 32'h300, 1'b0);
    push_cmd(1'b0, 32'h200, 1'b1); push_cmd(1'b1, 32'h300, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    m1_bus.cmd_valid = 1'b0; m0_bus.cmd_addr = 32'h204;
    @(negedge clk);
    check("full_s_cmd_valid", 64'(s_bus.cmd_valid), 64'd0);
    check("full_cnt", 64'(outstanding_cnt), 64'd4);
    check("full_m0_ready", 64'(m0_bus.cmd_ready), 64'd0);
    tick();
    s_bus.rsp_valid = 1'b1; s_bus.rsp_rdata = 32'hA0;
    push_rsp(1'b0, 32'hA0);
    @(negedge clk);
    check("full_pop_same_cycle", 64'(s_bus.cmd_valid), 64'd0);
    tick();
    s_bus.rsp_valid = 1'b0;
    push_cmd(1'b0, 32'h204, 1'b1);
    @(negedge clk);
    check("full_unblocked", 64'(s_bus.cmd_valid), 64'd1);
    tick();
    m0_bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_bus.rsp_valid = 1'b1; s_bus.rsp_rdata = 32'hB0 + 32'(i);
      push_rsp((i % 2) == 0, 32'hB0 + 32'(i));
      tick();
    end
    s_bus.rsp_valid = 1'b0;
    @(negedge clk);
    check("drain_cnt", 64'(outstanding_cnt), 64'd0);
    tick();

    // Lock: slave stalls with both masters valid
    do_reset();
    s_bus.cmd_ready = 1'b0;
    m0_bus.cmd_valid = 1'b1; m0_bus.cmd_addr = 32'h400; m0_bus.cmd_read = 1'b1;
    m1_bus.cmd_valid = 1'b1; m1_bus.cmd_addr = 32'h500; m1_bus.cmd_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lock_addr", 64'(s_bus.cmd_addr), 64'h400);
      check("lock_m1_ready", 64'(m1_bus.cmd_ready), 64'd0);
      tick();
    end
    s_bus.cmd_ready = 1'b1;
    push_cmd(1'b0, 32'h400, 1'b1); push_cmd(1'b1, 32'h500, 1'b1);
    tick();
    m0_bus.cmd_valid = 1'b0;
    tick();
    m1_bus.cmd_valid = 1'b0;
    s_bus.rsp_valid = 1'b1; s_bus.rsp_rdata = 32'hC0; push_rsp(1'b0, 32'hC0);
    tick();
    s_bus.rsp_rdata = 32'hC1; push_rsp(1'b1, 32'hC1);
    tick();
    s_bus.rsp_valid = 1'b0;

    // Lock holds m1 even though the tie would now favour m0
    s_bus.cmd_ready = 1'b0;
    m1_bus.cmd_valid = 1'b1; m1_bus.cmd_addr = 32'h600;
    tick();
    m0_bus.cmd_valid = 1'b1; m0_bus.cmd_addr = 32'h700;
    @(negedge clk);
    check("lock_hold_m1", 64'(s_bus.cmd_addr), 64'h600);
    tick();
    s_bus.cmd_ready = 1'b1;
    push_cmd(1'b1, 32'h600, 1'b1); push_cmd(1'b0, 32'h700, 1'b1);
    tick();
    m1_bus.cmd_valid = 1'b0;
    tick();
    m0_bus.cmd_valid = 1'b0;
    s_bus.rsp_valid = 1'b1; s_bus.rsp_rdata = 32'hD0; push_rsp(1'b1, 32'hD0);
    tick();
    s_bus.rsp_rdata = 32'hD1; push_rsp(1'b0, 32'hD1);
    tick();
    s_bus.rsp_valid = 1'b0;

    // Ordering with master backpressure: m1 write then m0 read
    m1_bus.cmd_valid = 1'b1; m1_bus.cmd_addr = 32'h800; m1_bus.cmd_read = 1'b0;
    m1_bus.cmd_wdata = 32'h1234_5678; m1_bus.cmd_wmask = 4'h3;
    push_cmd(1'b1, 32'h800, 1'b0);
    tick();
    m1_bus.cmd_valid = 1'b0;
    m0_bus.cmd_valid = 1'b1; m0_bus.cmd_addr = 32'h900; m0_bus.cmd_read = 1'b1;
    push_cmd(1'b0, 32'h900, 1'b1);
    tick();
    m0_bus.cmd_valid = 1'b0;
    m1_bus.rsp_ready = 1'b0;
    s_bus.rsp_valid = 1'b1; s_bus.rsp_rdata = 32'h111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_s_rsp_ready", 64'(s_bus.rsp_ready), 64'd0);
      check("bp_no_early_m0", 64'(m0_bus.rsp_valid), 64'd0);
      check("bp_m1_valid", 64'(m1_bus.rsp_valid), 64'd1);
      tick();
    end
    m1_bus.rsp_ready = 1'b1;
    push_rsp(1'b1, 32'h111);
    tick();
    s_bus.rsp_rdata = 32'h222; push_rsp(1'b0, 32'h222);
    tick();
    s_bus.rsp_valid = 1'b0;

    // Asynchronous reset with three commands in flight
    m0_bus.cmd_valid = 1'b1; m0_bus.cmd_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m0_bus.cmd_addr = 32'hA00 + 32'(i);
      push_cmd(1'b0, 32'hA00 + 32'(i), 1'b1);
      tick();
    end
    m0_bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("inflight_cnt", 64'(outstanding_cnt), 64'd3);
    s_bus.rsp_valid = 1'b1; s_bus.rsp_rdata = 32'hBAD;
    sys_resetn = 1'b0;
    #1;
    check("async_rst_cnt", 64'(outstanding_cnt), 64'd0);
    check("async_rst_rsp_ready", 64'(s_bus.rsp_ready), 64'd0);
    tick();
    sys_resetn = 1'b1;
    @(negedge clk);
    check("stray_rsp_ready", 64'(s_bus.rsp_ready), 64'd0);
    check("stray_m0_rsp_valid", 64'(m0_bus.rsp_valid), 64'd0);
    tick();
    s_bus.rsp_valid = 1'b0;
    tick();

    check("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
    check("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/icb_mem_arbiter.md
# icb_mem_arbiter

Two-master to one-slave ICB arbiter that shares a single memory port between the core's instruction bus (m0) and data bus (m1). It sits between the panda_risc_v core and a unified memory or peripheral slave in the sim top. The arbiter grants commands round-robin and tracks granted commands in an in-order ID FIFO. Responses are steered back to the issuing master with no reordering.

## Interface
- OUTSTANDING_N, 4: maximum accepted-but-unanswered commands (1 | 2 | 4 | 8)
- SIM_DELAY, 1: delay applied to all register updates (simulation only)
- clk  input  1  clock
- sys_resetn  input  1  asynchronous active-low reset
- m{0,1}_cmd_addr  input  32  command address
- m{0,1}_cmd_read  input  1  1 = read, 0 = write
- m{0,1}_cmd_wdata  input  32  write data
- m{0,1}_cmd_wmask  input  4  byte write mask
- m{0,1}_cmd_valid  input  1  command valid
- m{0,1}_cmd_ready  output  1  command accepted
- m{0,1}_rsp_rdata  output  32  read data
- m{0,1}_rsp_err  output  1  response error
- m{0,1}_rsp_valid  output  1  response valid
- m{0,1}_rsp_ready  input  1  master can take the response
- s_cmd_addr / s_cmd_read / s_cmd_wdata / s_cmd_wmask  output  32/1/32/4  muxed command
- s_cmd_valid  output  1  muxed command valid
- s_cmd_ready  input  1  slave accepts the command
- s_rsp_rdata / s_rsp_err  input  32/1  slave response
- s_rsp_valid  input  1  slave response valid
- s_rsp_ready  output  1  response consumed
- outstanding_cnt  output  4  commands currently in flight

## Operation
- The ID FIFO has depth OUTSTANDING_N. Each entry is 1 bit: the ID of the master whose command the slave accepted.
  - full when the entry count equals OUTSTANDING_N.
  - empty when the entry count is 0.
- Selection sel:
  - If lock = 1, sel = lock_id.
  - Else, if only one master is valid, sel = that master.
  - Else, if both are valid, sel = the master that is not last_id.
- Command path:
  - s_cmd_valid = (m0_cmd_valid | m1_cmd_valid) & ~full.
  - s_cmd_* fields = m[sel]_cmd_*.
  - m[sel]_cmd_ready = s_cmd_ready & ~full; the other master's cmd_ready = 0.
- Lock:
  - When s_cmd_valid = 1 and s_cmd_ready = 0, set lock = 1 and lock_id = sel.
  - Clear lock on the next s_cmd handshake.
  - Purpose: the offered command stays stable until accepted (ICB rule), and a master that waits is never pre-empted.
- On an s_cmd handshake: push sel into the FIFO, set last_id = sel, clear lock.
- Response path:
  - h = FIFO head ID.
  - m[h]_rsp_valid = s_rsp_valid & ~empty.
  - m[h]_rsp_rdata / m[h]_rsp_err = s_rsp_rdata / s_rsp_err.
  - The other master's rsp_valid = 0.
  - s_rsp_ready = m[h]_rsp_ready & ~empty.
- On an s_rsp handshake, pop the FIFO.
- Simultaneous push and pop: entry count is unchanged; the pointers still advance.
- Full: s_cmd_valid is forced low; a pop in the same cycle does not unblock the command until the next cycle.
- Empty: s_rsp_ready = 0; any stray slave response is held off.
- Pointers wrap modulo OUTSTANDING_N.
- outstanding_cnt equals the FIFO entry count.

## Timing
- Command and response muxing are combinational: 0-cycle latency through the arbiter. The slave must return a response at least 1 cycle after accepting the command.
- FIFO, lock, lock_id and last_id update on the rising clk edge, after SIM_DELAY.
- Reset values:
  - FIFO empty, outstanding_cnt = 0, lock = 0.
  - last_id = 1, so m0 wins the first tie.
  - All ready/valid outputs are derived and are therefore 0 while inputs are idle.
- Reset mid-operation clears all in-flight tracking. Slave responses arriving after reset are blocked (empty FIFO) until new commands are issued.
- Back-to-back commands are accepted at 1 per cycle when s_cmd_ready stays high and the FIFO is not full.

## Test plan
- Single master:
  - m0 issues a read to 0x100.
  - Slave accepts immediately and responds 2 cycles later with 0xDEADBEEF.
  - Required: m0_rsp_rdata = 0xDEADBEEF, m1_rsp_valid stays 0, outstanding_cnt goes 0 → 1 → 0.
- Tie and round-robin:
  - m0 and m1 are both valid every cycle; slave is always ready.
  - Required: grants alternate m0, m1, m0, m1, starting with m0 after reset.
- Lock:
  - Both masters valid; s_cmd_ready held 0 for 3 cycles.
  - Required: s_cmd_addr stays at m0's address for all 3 cycles, and the grant switches only after the handshake.
- Full:
  - OUTSTANDING_N = 4; 4 reads accepted with no responses returned.
  - Required: s_cmd_valid = 0 and outstanding_cnt = 4. One response pops the FIFO; the next cycle accepts a new command.
- Ordering and backpressure:
  - Issue m1 write then m0 read; hold m1_rsp_ready = 0 for 2 cycles.
  - Required: s_rsp_ready = 0 during those cycles, the m0 response is not delivered early, and the responses arrive in order m1, m0.
- Reset mid-flight:
  - Assert sys_resetn low with 3 commands outstanding.
  - Required: outstanding_cnt = 0 and s_rsp_ready = 0 immediately (asynchronous reset).
